// File: rtl/uart_rx_if.sv
// ============================================================================
// Module      : uart_rx_if
// Description : Serial-in / parallel-out bundle between a UART receiver and
//               the host logic that consumes its bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 tick;
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_error;
    logic                 busy;

    modport master (
        output tick,
        output rx,
        input  data,
        input  valid,
        input  frame_error,
        input  busy
    );

    modport slave (
        input  tick,
        input  rx,
        output data,
        output valid,
        output frame_error,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : Oversampling 8N1-style UART receiver with start-bit
//               validation, LSB-first capture and framing-error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    uart_rx_if.slave  bus
);
    localparam int c_tick_w = $clog2(OVERSAMPLE);
    localparam int c_bit_w  = $clog2(DATA_BITS);
    localparam logic [c_tick_w-1:0] c_tick_mid  = c_tick_w'(OVERSAMPLE/2 - 1);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [c_tick_w-1:0]  tick_cnt_q, tick_cnt_d;
    logic [c_bit_w-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_error_q, frame_error_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            rx_meta_q     <= bus.rx;
            rx_s_q        <= rx_meta_q;
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_d        = data_q;
        valid_d       = 1'b0;
        frame_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (bus.tick) begin
                    if (tick_cnt_q == c_tick_mid) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s_q ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + c_tick_w'(1);
                    end
                end
            end
            DATA: begin
                if (bus.tick) begin
                    if (tick_cnt_q == c_tick_last) begin
                        // Right shift: the first bit received ends up at the LSB.
                        shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + c_bit_w'(1);
                        if (bit_cnt_q == c_bit_last) state_d = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + c_tick_w'(1);
                    end
                end
            end
            STOP: begin
                if (bus.tick) begin
                    if (tick_cnt_q == c_tick_last) begin
                        tick_cnt_d = '0;
                        if (rx_s_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            frame_error_d = 1'b1;
                            state_d       = WAIT_HIGH;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + c_tick_w'(1);
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must not be mistaken for a new start bit.
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.data        = data_q;
    assign bus.valid       = valid_q;
    assign bus.frame_error = frame_error_q;
    assign bus.busy        = (state_q != IDLE);
endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx: table of frames plus
//               glitch, break, mid-frame reset and tick-gating sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;
    localparam int c_os = 16;

    logic clk;
    logic rst;
    logic tick_en;
    int   tcnt;
    int   cyc;
    int   checks;
    int   errors;
    int   start_cyc;
    int   last_pulse_cyc;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(c_os)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         gap_ticks;
        int         gate_bit;
        int         rst_bit;
        int         exp_pulse;  // 0 none, 1 valid, 2 frame_error
        logic [7:0] exp_data;
    } vec_t;

    typedef struct {
        logic       err;
        logic [7:0] d;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One tick every 4 clocks, updated on the falling edge.
    initial begin
        bus.tick = 1'b0;
        tcnt     = 0;
        forever begin
            @(negedge clk);
            tcnt     = (tcnt + 1) % 4;
            bus.tick = tick_en && (tcnt == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (bus.valid || bus.frame_error)) begin
            check("valid_fe_exclusive", 32'(bus.valid & bus.frame_error), 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual valid=%0b fe=%0b required none",
                         bus.valid, bus.frame_error);
            end else begin
                e = sb.pop_front();
                check("pulse_is_frame_error", 32'(bus.frame_error), 32'(e.err));
                check("rx_data", 32'(bus.data), 32'(e.d));
                last_pulse_cyc = cyc;
            end
        end
    end

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (bus.tick) k++;
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        @(negedge clk);
        bus.rx = b;
        wait_ticks(n);
    endtask

    task automatic wait_sb_empty();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        if (v.exp_pulse != 0) begin
            e.err = (v.exp_pulse == 2);
            e.d   = v.exp_data;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.rx    = 1'b0;
        start_cyc = cyc;
        wait_ticks(c_os);
        for (int i = 0; i < 8; i++) begin
            drive_bit(v.d[i], c_os/2);
            if (i == 4) check("busy_mid_frame", 32'(bus.busy), 32'd1);
            if (i == v.rst_bit) begin
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst    = 1'b0;
                bus.rx = 1'b1;
                check("rst_mid_data",  32'(bus.data),        32'd0);
                check("rst_mid_busy",  32'(bus.busy),        32'd0);
                check("rst_mid_valid", 32'(bus.valid),       32'd0);
                check("rst_mid_fe",    32'(bus.frame_error), 32'd0);
                wait_ticks(2*c_os);
                return;
            end
            if (i == v.gate_bit) begin
                @(negedge clk);
                tick_en = 1'b0;
                repeat (100) @(negedge clk);
                check("busy_while_gated", 32'(bus.busy), 32'd1);
                tick_en = 1'b1;
            end
            wait_ticks(c_os/2);
        end
        drive_bit(v.stop, c_os);
        if (!v.stop) begin
            // Hold a break for three more bit times; no new frame may start.
            wait_ticks(3*c_os);
            check("busy_during_break", 32'(bus.busy), 32'd1);
            @(negedge clk);
            bus.rx = 1'b1;
            repeat (4) @(negedge clk);
            check("busy_after_break", 32'(bus.busy), 32'd0);
        end
        if (v.gap_ticks > 0) drive_bit(1'b1, v.gap_ticks);
    endtask

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks         = 0;
        errors         = 0;
        cyc            = 0;
        last_pulse_cyc = 0;
        start_cyc      = 0;
        rst            = 1'b1;
        bus.rx         = 1'b1;
        tick_en        = 1'b1;

        //             data   stop  gap  gate rst  pulse exp_data
        vecs[0] = '{8'hA5, 1'b1, 16,  -1,  -1,  1,   8'hA5};
        vecs[1] = '{8'h00, 1'b1, 0,   -1,  -1,  1,   8'h00};
        vecs[2] = '{8'hFF, 1'b1, 16,  -1,  -1,  1,   8'hFF};
        vecs[3] = '{8'h3C, 1'b0, 16,  -1,  -1,  2,   8'hFF};
        vecs[4] = '{8'h5A, 1'b1, 16,  -1,  4,   0,   8'h00};
        vecs[5] = '{8'h81, 1'b1, 16,  -1,  -1,  1,   8'h81};
        vecs[6] = '{8'hC3, 1'b1, 16,  3,   -1,  1,   8'hC3};
        vecs[7] = '{8'h6E, 1'b1, 16,  -1,  -1,  1,   8'h6E};

        repeat (5) @(negedge clk);
        check("reset_data",  32'(bus.data),        32'd0);
        check("reset_valid", 32'(bus.valid),       32'd0);
        check("reset_fe",    32'(bus.frame_error), 32'd0);
        check("reset_busy",  32'(bus.busy),        32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Glitch: low for only 4 ticks, well short of the mid-bit sample.
        drive_bit(1'b0, 4);
        check("glitch_busy_rises", 32'(bus.busy), 32'd1);
        drive_bit(1'b1, 12);
        check("glitch_busy_falls", 32'(bus.busy), 32'd0);
        wait_ticks(c_os);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
            if (i == 0)
                check("first_valid_latency_in_window",
                      32'((last_pulse_cyc - start_cyc >= 600) && (last_pulse_cyc - start_cyc <= 620)),
                      32'd1);
            if (vecs[i].gap_ticks > 0) wait_sb_empty();
        end

        wait_ticks(2*c_os);
        check("final_busy", 32'(bus.busy), 32'd0);
        check("final_data", 32'(bus.data), 32'h6E);
        wait_sb_empty();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
